// File: rtl/pacemaker_dual_chamber_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pacemaker_pkg
// Purpose  : Shared types and default interval constants for the
//            dual-chamber pacemaker controller.
// Contents : state_t         - controller state encoding (3 bits)
//            DEF_CNT_W       - default timer width
//            DEF_VA_CYCLES   - default ventricular-to-atrial escape interval
//            DEF_AV_CYCLES   - default atrial-to-ventricular escape interval
// Revision : 1.0 - initial release
// ============================================================================
package pacemaker_pkg;

    typedef enum logic [2:0] {
        RST_VA = 3'd0,
        WAIT_A = 3'd1,
        PACE_A = 3'd2,
        RST_AV = 3'd3,
        WAIT_V = 3'd4,
        PACE_V = 3'd5
    } state_t;

    localparam int DEF_CNT_W     = 16;
    localparam int DEF_VA_CYCLES = 40;
    localparam int DEF_AV_CYCLES = 20;

endpackage
`default_nettype wire

// File: rtl/pacemaker_dual_chamber_if.sv
`default_nettype none
// ============================================================================
// Module   : pacemaker_dual_chamber_if
// Purpose  : Sense/pace signal bundle between the sense front-end, the
//            pacemaker controller and the pace driver.
// Signals  : sa - atrial sense pulse        (front-end -> controller)
//            sv - ventricular sense pulse   (front-end -> controller)
//            pa - atrial pace pulse         (controller -> driver)
//            pv - ventricular pace pulse    (controller -> driver)
// Modports : master - drives senses, observes paces
//            slave  - the controller: consumes senses, drives paces
// Revision : 1.0 - initial release
// ============================================================================
interface pacemaker_dual_chamber_if;
    logic sa;
    logic sv;
    logic pa;
    logic pv;

    modport master (output sa, output sv, input pa, input pv);
    modport slave  (input sa, input sv, output pa, output pv);
endinterface
`default_nettype wire

// File: rtl/pacemaker_dual_chamber_timer.sv
`default_nettype none
// ============================================================================
// Module   : pace_timer
// Purpose  : Escape-interval down-counter. Loads an interval, counts down
//            while enabled and flags expiry when the count reaches 1.
//            The count never goes below 1 once loaded and never wraps.
// Ports    : clk      - system clock
//            rst      - asynchronous active-low reset (count cleared to 0)
//            load     - load load_val into the count
//            load_val - interval to load
//            dec      - decrement request (ignored when count <= 1)
//            expire   - high while count == 1
// Revision : 1.0 - initial release
// ============================================================================
module pace_timer #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             dec,
    output logic                  expire
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count > C_ONE)) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign expire = (r_count == C_ONE);

endmodule
`default_nettype wire

// File: rtl/pacemaker_dual_chamber.sv
`default_nettype none
// ============================================================================
// Module   : pacemaker_dual_chamber
// Purpose  : Simplified DDD-style dual-chamber pacemaker controller.
//            Paces the atrium when no atrial sense arrives within
//            VA_CYCLES of a ventricular event, and paces the ventricle when
//            no ventricular sense follows within AV_CYCLES of an atrial event.
// Ports    : clk - system clock
//            rst - asynchronous active-low reset
//            bus - slave modport: sa/sv senses in, pa/pv one-cycle paces out
// Revision : 1.0 - initial release
// ============================================================================
module pacemaker_dual_chamber
    import pacemaker_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int VA_CYCLES = DEF_VA_CYCLES,
    parameter int AV_CYCLES = DEF_AV_CYCLES
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pacemaker_dual_chamber_if.slave   bus
);

    localparam logic [CNT_W-1:0] C_VA = CNT_W'(VA_CYCLES);
    localparam logic [CNT_W-1:0] C_AV = CNT_W'(AV_CYCLES);

    state_t           r_state;
    logic             r_pa;
    logic             r_pv;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_expire;

    // The timer is reloaded in each RST state and counts only while its
    // WAIT state has not seen the watched sense.
    assign w_load     = (r_state == RST_VA) || (r_state == RST_AV);
    assign w_load_val = (r_state == RST_AV) ? C_AV : C_VA;
    assign w_dec      = ((r_state == WAIT_A) && !bus.sa) ||
                        ((r_state == WAIT_V) && !bus.sv);

    pace_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .expire   (w_expire)
    );

    // Pace outputs are registered alongside the state: each is set on the
    // same edge that enters its PACE state, so they track the state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_VA;
            r_pa    <= 1'b0;
            r_pv    <= 1'b0;
        end else begin
            r_pa <= 1'b0;
            r_pv <= 1'b0;
            case (r_state)
                RST_VA: r_state <= WAIT_A;
                WAIT_A: begin
                    // Sense takes priority over a same-cycle timeout.
                    if (bus.sa) begin
                        r_state <= RST_AV;
                    end else if (w_expire) begin
                        r_state <= PACE_A;
                        r_pa    <= 1'b1;
                    end
                end
                PACE_A: r_state <= RST_AV;
                RST_AV: r_state <= WAIT_V;
                WAIT_V: begin
                    if (bus.sv) begin
                        r_state <= RST_VA;
                    end else if (w_expire) begin
                        r_state <= PACE_V;
                        r_pv    <= 1'b1;
                    end
                end
                PACE_V: r_state <= RST_VA;
                default: r_state <= RST_VA;
            endcase
        end
    end

    assign bus.pa = r_pa;
    assign bus.pv = r_pv;

endmodule
`default_nettype wire

// File: tb/tb_pacemaker_dual_chamber.sv
`default_nettype none
// ============================================================================
// Module   : tb_pacemaker_dual_chamber
// Purpose  : Directed self-checking bench for pacemaker_dual_chamber with
//            default intervals (VA=40, AV=20). Cycle n is the n-th rising
//            edge after reset release; outputs for cycle n are sampled on the
//            falling edge just before edge n, where the senses for cycle n
//            are also applied.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pacemaker_dual_chamber;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pacemaker_dual_chamber_if bus ();

    pacemaker_dual_chamber #(
        .CNT_W     (16),
        .VA_CYCLES (40),
        .AV_CYCLES (20)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Reset, release, then run ncyc cycles with sa held over [sa_lo,sa_hi]
    // and sv over [sv_lo,sv_hi]; pa must be high only at pa1/pa2 and pv only
    // at pv1/pv2 (-1 = unused). If rst_at >= 0, reset is asserted in the
    // middle of that cycle and the paces must drop without a clock edge.
    task automatic run_scen(input string name,
                            input int sa_lo, input int sa_hi,
                            input int sv_lo, input int sv_hi,
                            input int pa1, input int pa2,
                            input int pv1, input int pv2,
                            input int ncyc, input int rst_at);
        bus.sa = 1'b0;
        bus.sv = 1'b0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        check_bit({name, " reset pa"}, bus.pa, 1'b0);
        check_bit({name, " reset pv"}, bus.pv, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            bus.sa = (c >= sa_lo) && (c <= sa_hi);
            bus.sv = (c >= sv_lo) && (c <= sv_hi);
            check_bit($sformatf("%s c%0d pa", name, c), bus.pa, logic'((c == pa1) || (c == pa2)));
            check_bit($sformatf("%s c%0d pv", name, c), bus.pv, logic'((c == pv1) || (c == pv2)));
            if (c == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check_bit({name, " async pa"}, bus.pa, 1'b0);
                check_bit({name, " async pv"}, bus.pv, 1'b0);
                bus.sa = 1'b0;
                bus.sv = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.sa = 1'b0;
        bus.sv = 1'b0;
    endtask

    initial begin
        bus.sa = 1'b0;
        bus.sv = 1'b0;
        // Free-running: pa 41, pv 63, pa 105 (period 64).
        run_scen("free",     -1, -1, -1, -1, 41, 105, 63, -1, 110, -1);
        // Atrial sense at 10: RST_AV 11, WAIT_V 12..31, pv 32, next pa 74.
        run_scen("sa10",     10, 10, -1, -1, 74,  -1, 32, -1,  80, -1);
        // Same sense held 10..14: counted once, ignored by RST_AV/WAIT_V.
        run_scen("sa_held",  10, 14, -1, -1, 74,  -1, 32, -1,  80, -1);
        // Ventricular sense at 50 after pa 41: RST_VA 51, next pa 92.
        run_scen("sv50",     -1, -1, 50, 50, 41,  92, -1, -1,  95, -1);
        // Sense on the expiry cycle 40 wins: no pa, pv 62.
        run_scen("sa40",     40, 40, -1, -1, -1,  -1, 62, -1,  66, -1);
        // sv in WAIT_A and sa in WAIT_V are ignored.
        run_scen("ignored",  50, 50, 20, 20, 41, 105, 63, -1, 110, -1);
        // Reset mid-PACE_V, then recovery paces atrium at cycle 41 again.
        run_scen("rst_pv",   -1, -1, -1, -1, 41,  -1, 63, -1,  70, 63);
        run_scen("recover",  -1, -1, -1, -1, 41,  -1, -1, -1,  45, -1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
